// File: rtl/writeback_stage_pkg.sv
// Shared types for the RV32I writeback stage: data width, register index,
// register-file write bundle and load funct3 encodings.
package writeback_stage_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [4:0]      rv_reg_t;
  typedef logic [XLEN-1:0] rv_word_t;

  typedef struct packed {
    logic     enable;
    rv_reg_t  which_register;
    rv_word_t value;
  } reg_write_control_t;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_t;

endpackage

// File: rtl/writeback_stage_if.sv
// Memory-stage handshake, register-file write port and decode hazard query
// for the writeback stage. master = environment side, slave = writeback_stage.
interface writeback_stage_if;
  import writeback_stage_pkg::*;

  logic               in_valid;
  logic               in_ready;
  rv_reg_t            in_rd;
  rv_word_t           in_result;
  logic               in_is_load;
  logic [2:0]         in_load_funct3;
  rv_word_t           in_mem_rdata;
  logic [1:0]         in_addr_lsb;
  logic               write_grant;
  reg_write_control_t write_control;
  rv_reg_t            query_rs1;
  rv_reg_t            query_rs2;
  logic               rs1_pending;
  logic               rs2_pending;

  modport master (
    output in_valid, in_rd, in_result, in_is_load, in_load_funct3,
           in_mem_rdata, in_addr_lsb, write_grant, query_rs1, query_rs2,
    input  in_ready, write_control, rs1_pending, rs2_pending
  );

  modport slave (
    input  in_valid, in_rd, in_result, in_is_load, in_load_funct3,
           in_mem_rdata, in_addr_lsb, write_grant, query_rs1, query_rs2,
    output in_ready, write_control, rs1_pending, rs2_pending
  );

endinterface

// File: rtl/writeback_stage_load_align.sv
// Load data alignment: selects the byte/halfword addressed by addr_lsb and
// sign- or zero-extends it; LW and undefined funct3 pass the full word.
module writeback_stage_load_align
  import writeback_stage_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lsb,
  input  rv_word_t   rdata,
  output rv_word_t   value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lsb)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lsb[1] ? rdata[31:16] : rdata[15:0];

    value = rdata;
    case (funct3)
      F3_LB:   value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  value = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   value = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  value = {{(XLEN-16){1'b0}}, half_sel};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// RV32I writeback stage: aligns load data, buffers results in a DEPTH-entry FIFO
// and drains to the register file. Optional retire counter: WB_RETIRE_COUNT_EN.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2
)(
  input  logic               clock,
  input  logic               reset,
  writeback_stage_if.slave   wb
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [63:0]        instret
`endif
);

  localparam int unsigned      PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;
  logic [DEPTH-1:0] entry_valid;
  rv_reg_t          entry_rd    [DEPTH];
  rv_word_t         entry_value [DEPTH];

  rv_word_t load_value;
  rv_word_t enq_value;
  rv_reg_t  head_rd;
  logic     enq, deq;

  writeback_stage_load_align u_load_align (
    .funct3   (wb.in_load_funct3),
    .addr_lsb (wb.in_addr_lsb),
    .rdata    (wb.in_mem_rdata),
    .value    (load_value)
  );

  // Full refuses input even while draining: no same-cycle pass-through.
  assign wb.in_ready = !reset && (count != FULL_COUNT);
  assign enq         = wb.in_valid && wb.in_ready;
  assign deq         = !reset && (count != '0) && wb.write_grant;
  assign enq_value   = wb.in_is_load ? load_value : wb.in_result;
  assign head_rd     = entry_rd[rd_ptr];

  always_comb begin
    wb.write_control.enable         = deq && (head_rd != '0);
    wb.write_control.which_register = head_rd;
    wb.write_control.value          = entry_value[rd_ptr];
  end

  always_comb begin
    wb.rs1_pending = 1'b0;
    wb.rs2_pending = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && entry_rd[i] == wb.query_rs1) wb.rs1_pending = 1'b1;
      if (entry_valid[i] && entry_rd[i] == wb.query_rs2) wb.rs2_pending = 1'b1;
    end
    if (reset || wb.query_rs1 == '0) wb.rs1_pending = 1'b0;
    if (reset || wb.query_rs2 == '0) wb.rs2_pending = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      entry_valid <= '0;
    end else begin
      if (deq) begin
        entry_valid[rd_ptr] <= 1'b0;
        rd_ptr              <= rd_ptr + 1'b1;
      end
      if (enq) begin
        entry_valid[wr_ptr] <= 1'b1;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (enq) begin
      entry_rd[wr_ptr]    <= wb.in_rd;
      entry_value[wr_ptr] <= enq_value;
    end
  end

`ifdef WB_RETIRE_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset)    instret <= '0;
    else if (deq) instret <= instret + 64'd1;
  end
`endif

endmodule
